// File: rtl/hwpe_stream_fifo_credit_tx.sv
// hwpe_stream_fifo_credit_tx: credit-based producer for a non-backpressured link into a remote FIFO.
// Define HWPE_STREAM_CREDIT_TX_ERR_EN to build the sticky credit-overflow error register.
module hwpe_stream_fifo_credit_tx #(
    parameter int unsigned CREDITS    = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic                             push_valid_i,
    input  logic [DATA_WIDTH-1:0]            push_data_i,
    output logic                             push_ready_o,
    output logic                             tx_valid_o,
    output logic [DATA_WIDTH-1:0]            tx_data_o,
    input  logic                             credit_i,
    output logic [$clog2(CREDITS+1)-1:0]     credits_o,
    output logic                             idle_o,
    output logic                             stall_o,
    output logic                             err_o
);
    localparam int unsigned CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] MAX = CW'(CREDITS);
    typedef enum logic [1:0] {IDLE, ACTIVE, STALL} state_t;
    state_t        state, state_next;
    logic [CW-1:0] count, count_next;
    logic          accept, overflow;
    // Readiness comes only from the registered count, so credit_i never reaches it combinationally.
    assign push_ready_o = count != '0;
    assign credits_o    = count;
    assign idle_o       = state == IDLE;
    assign stall_o      = state == STALL;
    // Next credit count and state: a same-cycle accept and credit cancel; an excess credit saturates.
    always_comb begin
        accept     = push_valid_i && push_ready_o;
        overflow   = credit_i && !accept && count == MAX;
        count_next = (accept && !credit_i) ? count - 1'b1 :
                     (credit_i && !accept && !overflow) ? count + 1'b1 : count;
        state_next = count_next == MAX ? IDLE : count_next == '0 ? STALL : ACTIVE;
    end
    // Credit state machine and registered link beat; a beat accepted during clear is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count      <= MAX;
            state      <= IDLE;
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
        end else if (clear_i) begin
            count      <= MAX;
            state      <= IDLE;
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
        end else begin
            count      <= count_next;
            state      <= state_next;
            tx_valid_o <= accept;
            if (accept) tx_data_o <= push_data_i;
        end
    end
`ifdef HWPE_STREAM_CREDIT_TX_ERR_EN
    logic err;
    assign err_o = err;
    // Sticky overflow flag: only reset or clear can drop it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err <= 1'b0;
        end else if (clear_i) begin
            err <= 1'b0;
        end else begin
            assert (!overflow) else $warning("credit_tx: credit returned with all credits home");
            if (overflow) err <= 1'b1;
        end
    end
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_hwpe_stream_fifo_credit_tx.sv
// tb_hwpe_stream_fifo_credit_tx: directed and random checks of the credit transmitter (CREDITS=8 and CREDITS=1).
module tb_hwpe_stream_fifo_credit_tx;
`ifdef HWPE_STREAM_CREDIT_TX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    logic        clk_i = 1'b0, rst_ni = 1'b0, clr = 1'b0;
    logic        v = 1'b0, c = 1'b0, v1 = 1'b0, c1 = 1'b0;
    logic [31:0] d = '0, d1 = '0;
    logic        a_ready, a_valid, a_idle, a_stall, a_err;
    logic        b_ready, b_valid, b_idle, b_stall, b_err;
    logic [31:0] a_data, b_data;
    logic [3:0]  a_credits;
    logic [0:0]  b_credits;
    int          n_chk = 0, n_fail = 0;
    int          m_cr = 8, m1_cr = 1;
    bit          m_v, m1_v, m_err, m1_err;
    logic [31:0] m_d, m1_d;

    always #5 clk_i = ~clk_i;

    hwpe_stream_fifo_credit_tx #(.CREDITS(8), .DATA_WIDTH(32)) dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clr),
        .push_valid_i(v), .push_data_i(d), .push_ready_o(a_ready),
        .tx_valid_o(a_valid), .tx_data_o(a_data), .credit_i(c),
        .credits_o(a_credits), .idle_o(a_idle), .stall_o(a_stall), .err_o(a_err)
    );

    hwpe_stream_fifo_credit_tx #(.CREDITS(1), .DATA_WIDTH(32)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clr),
        .push_valid_i(v1), .push_data_i(d1), .push_ready_o(b_ready),
        .tx_valid_o(b_valid), .tx_data_o(b_data), .credit_i(c1),
        .credits_o(b_credits), .idle_o(b_idle), .stall_o(b_stall), .err_o(b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cr = 8; m_v = 0; m_d = '0; m_err = 0;
        m1_cr = 1; m1_v = 0; m1_d = '0; m1_err = 0;
    endtask

    task automatic check_all();
        check("a_ready", a_ready, m_cr > 0);
        check("a_valid", a_valid, m_v);
        check("a_data", a_data, m_d);
        check("a_credits", a_credits, m_cr);
        check("a_idle", a_idle, m_cr == 8);
        check("a_stall", a_stall, m_cr == 0);
        check("a_err", a_err, m_err);
        check("b_ready", b_ready, m1_cr > 0);
        check("b_valid", b_valid, m1_v);
        check("b_data", b_data, m1_d);
        check("b_credits", b_credits, m1_cr);
        check("b_idle", b_idle, m1_cr == 1);
        check("b_stall", b_stall, m1_cr == 0);
        check("b_err", b_err, m1_err);
    endtask

    // One clock with the currently driven inputs; the model counts credits as plain saturating arithmetic.
    task automatic tick();
        bit a, a1;
        a  = v && m_cr > 0;
        a1 = v1 && m1_cr > 0;
        @(posedge clk_i);
        if (clr) begin
            model_reset();
        end else begin
            if (c && !a && m_cr == 8) m_err = m_err | ERR_EN;
            if (c1 && !a1 && m1_cr == 1) m1_err = m1_err | ERR_EN;
            m_cr  = m_cr - int'(a) + int'(c);
            m1_cr = m1_cr - int'(a1) + int'(c1);
            if (m_cr > 8) m_cr = 8;
            if (m1_cr > 1) m1_cr = 1;
            m_v  = a;
            m1_v = a1;
            if (a) m_d = d;
            if (a1) m1_d = d1;
        end
        @(negedge clk_i);
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk_i);
        check("rst_ready", a_ready, 1);
        check("rst_valid", a_valid, 0);
        check("rst_data", a_data, 0);
        check("rst_credits", a_credits, 8);
        check("rst_idle", a_idle, 1);
        check("rst_stall", a_stall, 0);
        check("rst_err", a_err, 0);
        rst_ni = 1'b1;
        // burst to stall
        for (int i = 0; i < 8; i++) begin
            v = 1; d = i; tick();
            check("burst_valid", a_valid, 1);
            check("burst_data", a_data, i);
        end
        d = 8;
        repeat (2) tick();
        check("burst_ready", a_ready, 0);
        check("burst_stall", a_stall, 1);
        check("burst_credits", a_credits, 0);
        check("burst_held", a_valid, 0);
        // stall release
        c = 1; tick();
        check("release_ready", a_ready, 1);
        c = 0; tick();
        check("release_valid", a_valid, 1);
        check("release_data", a_data, 8);
        check("release_credits", a_credits, 0);
        // credit only at count 0
        d = 32'h55; c = 1; tick();
        check("zero_credit_cnt", a_credits, 1);
        check("zero_credit_noacc", a_valid, 0);
        v = 0; repeat (2) tick();
        // accept and credit together at count 3
        v = 1; d = 32'hA5; tick();
        check("simul_credits", a_credits, 3);
        check("simul_valid", a_valid, 1);
        check("simul_data", a_data, 32'hA5);
        // overflow at idle
        v = 0; repeat (5) tick();
        check("pre_ovf_idle", a_idle, 1);
        tick();
        check("ovf_credits", a_credits, 8);
        check("ovf_err", a_err, ERR_EN);
        c = 0; tick();
        check("ovf_err_sticky", a_err, ERR_EN);
        // clear mid-operation
        v = 1; d = 32'h11; repeat (6) tick();
        check("pre_clr_credits", a_credits, 2);
        d = 32'hDEAD; clr = 1; tick();
        clr = 0; v = 0;
        check("clr_credits", a_credits, 8);
        check("clr_idle", a_idle, 1);
        check("clr_valid", a_valid, 0);
        check("clr_data", a_data, 0);
        check("clr_err", a_err, 0);
        // CREDITS=1 corner: alternate push and credit
        for (int i = 0; i < 3; i++) begin
            v1 = 1; d1 = 32'h100 + i; c1 = 0; tick();
            check("c1_stall", b_stall, 1);
            check("c1_beat", b_data, 32'h100 + i);
            c1 = 1; d1 = 32'hBAD; tick();
            check("c1_idle", b_idle, 1);
            check("c1_noacc", b_valid, 0);
        end
        d1 = 32'h1F0; tick();
        check("c1_simul_cnt", b_credits, 1);
        check("c1_simul_valid", b_valid, 1);
        check("c1_simul_data", b_data, 32'h1F0);
        v1 = 0; c1 = 0;
        // asynchronous reset mid-burst
        v = 1; d = 32'h77; tick();
        check("pre_arst_valid", a_valid, 1);
        rst_ni = 1'b0;
        #1;
        check("arst_valid", a_valid, 0);
        check("arst_credits", a_credits, 8);
        check("arst_data", a_data, 0);
        model_reset();
        v = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        check("post_arst_valid", a_valid, 0);
        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            v = $urandom_range(0, 1); d = $urandom; c = ($urandom % 3) == 0;
            v1 = $urandom_range(0, 1); d1 = $urandom; c1 = ($urandom % 2) == 0;
            clr = ($urandom % 64) == 0;
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hwpe_stream_fifo_credit_tx.md
# hwpe_stream_fifo_credit_tx

Credit-based transmitter for the producer side of a point-to-point HWPE-Stream link whose receiver is a FIFO of known depth. It accepts an upstream push handshake, forwards each beat on a registered, non-backpressured link, and tracks the free slots in the remote FIFO with a credit counter. Slots are replenished by single-cycle credit pulses returned when the receiver pops. It sits in front of a remote FIFO built from a FIFO controller plus external storage, so that the receiver never overflows and the link needs no ready wire.

## Interface
- CREDITS, 8: depth of the remote FIFO; ≥1; initial and maximum credit count.
- DATA_WIDTH, 32: payload width.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous clear; same effect as reset.
- push_valid_i  in  1  upstream beat valid.
- push_data_i  in  DATA_WIDTH  upstream payload.
- push_ready_o  out  1  upstream ready; high iff credits > 0.
- tx_valid_o  out  1  link beat valid; registered single-cycle pulse per beat.
- tx_data_o  out  DATA_WIDTH  link payload; registered.
- credit_i  in  1  credit-return pulse from receiver; one credit per cycle high.
- credits_o  out  $clog2(CREDITS+1)  current credit count.
- idle_o  out  1  all credits home (credits_o == CREDITS).
- stall_o  out  1  no credits (credits_o == 0).
- err_o  out  1  sticky credit-overflow error; see Configuration.

## Operation
- Push handshake: a beat is accepted in a cycle when push_valid_i && push_ready_o.
- push_ready_o depends only on registered state, never combinationally on credit_i or push_valid_i.
- Credit counter update, each cycle:
  - accept and no credit_i: −1.
  - credit_i and no accept: +1.
  - accept and credit_i together: unchanged.
- Overflow: credit_i while the count is CREDITS and no accept is an overflow.
  - The count saturates at CREDITS.
  - err_o sets (if enabled).
- Underflow is impossible by construction, because the block accepts nothing at count 0.
- State machine, derived from the next count:
  - IDLE: count == CREDITS.
  - ACTIVE: 0 < count < CREDITS.
  - STALL: count == 0.
  - Transitions are IDLE↔ACTIVE↔STALL. With CREDITS==1 the states go IDLE↔STALL directly.
  - idle_o and stall_o decode the registered state.
- Data path:
  - An accepted beat is registered into tx_data_o, and tx_valid_o is set for exactly the next cycle.
  - tx_data_o holds its last value when tx_valid_o is low.
  - There is no link backpressure; the receiver must accept every tx_valid_o beat.
- Clear or reset:
  - count = CREDITS, state IDLE, tx_valid_o = 0, tx_data_o = 0, err_o = 0.
  - Any beat accepted in the same cycle as clear_i is dropped.
  - In-flight credits are discarded. The receiver must be cleared in the same cycle.

## Timing
- Reset values: push_ready_o=1, tx_valid_o=0, tx_data_o=0, credits_o=CREDITS, idle_o=1, stall_o=0, err_o=0.
- Latency: a beat accepted at edge N appears on tx_valid_o/tx_data_o in cycle N+1, i.e. 1 cycle.
- Throughput: one beat per cycle while credits > 0.
- A credit returned in cycle N is usable in cycle N+1. From STALL, credit_i in cycle N gives push_ready_o=1 in cycle N+1.
- Sustained full rate needs a round trip of ≤ CREDITS cycles.
- Asynchronous reset mid-burst: tx_valid_o drops immediately. No partial beat is emitted after reset release.

## Configuration
- HWPE_STREAM_CREDIT_TX_ERR_EN defined:
  - err_o is a sticky register, set on an overflow credit and cleared only by rst_ni or clear_i.
  - A simulation assertion also fires on overflow.
- HWPE_STREAM_CREDIT_TX_ERR_EN undefined:
  - err_o is tied to 0 and no error register exists.
  - Overflow still saturates the count silently.

## Test plan
- Burst to stall: CREDITS=8, push_valid_i held high with data 0..9 and no credits.
  - Required: 8 beats accepted; tx_valid_o pulses with data 0..7, each one cycle after acceptance.
  - Required: push_ready_o=0, stall_o=1 and credits_o=0 after the 8th beat; data 8 is held upstream.
- Stall release: from stall, pulse credit_i for one cycle.
  - Required: push_ready_o=1 in the next cycle; data 8 is sent; the count returns to 0.
- Simultaneous events: count=3, accept and credit_i in the same cycle.
  - Required: credits_o stays 3 and tx_valid_o=1 next cycle.
  - Repeat at count=0 with credit_i only: the count becomes 1 and there is no accept in that cycle.
- Overflow: at count=8 (idle), pulse credit_i.
  - Required: credits_o stays 8.
  - Required: err_o=1 with HWPE_STREAM_CREDIT_TX_ERR_EN, and stays 1 until clear_i; err_o=0 without the macro.
- Clear mid-operation: count=2 with a beat accepted in the same cycle as clear_i.
  - Required: next cycle credits_o=8, idle_o=1, tx_valid_o=0 and tx_data_o=0.
- CREDITS=1 corner: alternate push and credit_i.
  - Required: strict IDLE/STALL alternation and one beat per credit.
  - Required: a push and a credit in the same cycle at count 1 keep the count at 1.
